// File: rtl/scr1_pipe_ialu_muldiv_if.sv
// Command/result bundle between the IALU pipeline (master) and the iterative
// RV32M multiply/divide unit (slave).
//   rvm_cmd_vd_i  : command valid, held high until the result is taken
//   cmd_i         : RV32M funct3 (MUL..REMU)
//   op1_i / op2_i : rs1 (dividend) / rs2 (divisor)
//   rvm_res_rdy_o : one-cycle result-ready pulse
//   res_o         : result, meaningful only while rvm_res_rdy_o=1
//   busy_o        : unit is iterating or correcting
interface scr1_pipe_ialu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            rvm_cmd_vd_i;
  logic [2:0]      cmd_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            rvm_res_rdy_o;
  logic [XLEN-1:0] res_o;
  logic            busy_o;

  modport master (
    output rvm_cmd_vd_i, cmd_i, op1_i, op2_i,
    input  rvm_res_rdy_o, res_o, busy_o
  );

  modport slave (
    input  rvm_cmd_vd_i, cmd_i, op1_i, op2_i,
    output rvm_res_rdy_o, res_o, busy_o
  );
endinterface

// File: rtl/scr1_pipe_ialu_muldiv.sv
// Iterative RV32M multiply/divide unit for the IALU.
// Operands are latched as magnitudes plus sign flags; 32 radix-2 steps run in
// ITER (shift-add multiply or restoring divide), then CORR applies the sign
// fix-up and returns the selected word with a one-cycle rvm_res_rdy_o pulse.
// Ports:
//   clk   : IALU clock
//   rst_n : asynchronous active-low reset
//   rvm   : slave side of scr1_pipe_ialu_muldiv_if (command in, result out)
// Optional build macro SCR1_RVM_FAST_MUL_EN: multiplies use a combinational
// 33x33 signed multiplier and go IDLE -> CORR (result one cycle after the
// command); divides stay iterative.
module scr1_pipe_ialu_muldiv #(
  parameter int XLEN       = 32,
  parameter int ITER_CNT_W = 5
) (
  input logic                    clk,
  input logic                    rst_n,
  scr1_pipe_ialu_muldiv_if.slave rvm
);

  generate
    if (XLEN != 32 || ITER_CNT_W != 5) begin : g_bad_cfg
      $error("scr1_pipe_ialu_muldiv supports XLEN=32, ITER_CNT_W=5 only");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ITER, CORR} state_t;

  state_t                state, state_nxt;
  logic [ITER_CNT_W-1:0] cnt;
  logic [2*XLEN-1:0]     acc;      // mul: {partial hi, multiplier}; div: {rem, quo}
  logic [XLEN-1:0]       opr;      // mul: multiplicand; div: divisor magnitude
  logic [2:0]            cmd_r;
  logic                  s1_r, s2_r, dz_r;

  // Command decode on the live inputs (only used in IDLE)
  logic            is_div, sgn1, sgn2, neg1, neg2, is_fast;
  logic [XLEN-1:0] mag1, mag2;

  assign is_div = rvm.cmd_i[2];
  assign sgn1   = is_div ? ~rvm.cmd_i[0]
                         : (rvm.cmd_i[1:0] == 2'd1) || (rvm.cmd_i[1:0] == 2'd2);
  assign sgn2   = is_div ? ~rvm.cmd_i[0] : (rvm.cmd_i[1:0] == 2'd1);
  assign neg1   = sgn1 & rvm.op1_i[XLEN-1];
  assign neg2   = sgn2 & rvm.op2_i[XLEN-1];
  assign mag1   = neg1 ? -rvm.op1_i : rvm.op1_i;
  assign mag2   = neg2 ? -rvm.op2_i : rvm.op2_i;

`ifdef SCR1_RVM_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a, fm_b;
  logic signed [2*XLEN+1:0] fm_p;
  assign fm_a    = $signed({neg1, rvm.op1_i});
  assign fm_b    = $signed({neg2, rvm.op2_i});
  assign fm_p    = fm_a * fm_b;
  assign is_fast = ~is_div;
`else
  assign is_fast = 1'b0;
`endif

  // One multiply step: add multiplicand if multiplier LSB set, shift right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opr} : '0);
  assign mul_step = {mul_sum, acc[XLEN-1:1]};

  // One restoring divide step: shift {rem,quo} left, trial-subtract divisor.
  // rem < divisor always holds, so the shifted remainder needs only XLEN+1 bits.
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_step;
  assign div_sh   = acc[2*XLEN-1:XLEN-1];
  assign div_diff = {1'b0, div_sh} - {2'b0, opr};
  assign div_ok   = ~div_diff[XLEN+1];
  assign div_step = {div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0],
                     acc[XLEN-2:0], div_ok};

  // Sign correction; a zero divisor keeps the all-ones quotient as is, and the
  // remainder negation by dividend sign restores op1 exactly.
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   quo_c, rem_c, result;
  assign prod_c = (s1_r ^ s2_r) ? -acc : acc;
  assign quo_c  = ((s1_r ^ s2_r) & ~dz_r) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_c  = s1_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    case (cmd_r)
      3'd0:             result = prod_c[XLEN-1:0];
      3'd1, 3'd2, 3'd3: result = prod_c[2*XLEN-1:XLEN];
      3'd4, 3'd5:       result = quo_c;
      default:          result = rem_c;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rvm.rvm_cmd_vd_i) state_nxt = is_fast ? CORR : ITER;
      ITER:    if (!rvm.rvm_cmd_vd_i) state_nxt = IDLE;
               else if (cnt == '0)    state_nxt = CORR;
      CORR:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opr   <= '0;
      cmd_r <= '0;
      s1_r  <= 1'b0;
      s2_r  <= 1'b0;
      dz_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && rvm.rvm_cmd_vd_i) begin
        cmd_r <= rvm.cmd_i;
        cnt   <= ITER_CNT_W'(XLEN-1);
        dz_r  <= (rvm.op2_i == '0);
        opr   <= is_div ? mag2 : mag1;
        acc   <= {{XLEN{1'b0}}, is_div ? mag1 : mag2};
        s1_r  <= neg1;
        s2_r  <= neg2;
`ifdef SCR1_RVM_FAST_MUL_EN
        if (is_fast) begin
          // Product is already signed; no correction needed in CORR
          acc  <= fm_p[2*XLEN-1:0];
          s1_r <= 1'b0;
          s2_r <= 1'b0;
        end
`endif
      end else if (state == ITER) begin
        acc <= cmd_r[2] ? div_step : mul_step;
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Dropping valid in CORR is a flush: no pulse that cycle
  assign rvm.rvm_res_rdy_o = (state == CORR) & rvm.rvm_cmd_vd_i;
  assign rvm.res_o         = rvm.rvm_res_rdy_o ? result : '0;
  assign rvm.busy_o        = (state != IDLE);

endmodule

// File: tb/tb_scr1_pipe_ialu_muldiv.sv
// Self-checking bench for scr1_pipe_ialu_muldiv: directed RV32M cases, abort,
// asynchronous reset, back-to-back commands and randomized commands, checked
// against an arithmetic reference model.
module tb_scr1_pipe_ialu_muldiv;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scr1_pipe_ialu_muldiv_if #(.XLEN(XLEN)) bus ();

  scr1_pipe_ialu_muldiv #(.XLEN(XLEN), .ITER_CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rvm   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    r  = '0;
    case (c)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFFFFFF :
                (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a :
                (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] c);
`ifdef SCR1_RVM_FAST_MUL_EN
    return c[2] ? XLEN + 1 : 1;
`else
    return (c == c) ? XLEN + 1 : 0;
`endif
  endfunction

  // Starts just after a rising edge (cycle N); ends just after a rising edge.
  // keep=1 leaves valid high so the caller can present the next command.
  task automatic run(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                     input bit keep, input string tag);
    int          lat, lexp;
    logic [31:0] r, e;
    e    = model(c, a, b);
    lexp = lat_of(c);
    lat  = -1;
    r    = '0;
    bus.cmd_i = c; bus.op1_i = a; bus.op2_i = b; bus.rvm_cmd_vd_i = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (i == 0) chk({tag, "/busy0"}, 32'(bus.busy_o), 32'd0);
      if (i == 1) begin
        chk({tag, "/busy1"}, 32'(bus.busy_o), 32'd1);
        if (lexp > 1) chk({tag, "/res_idle"}, bus.res_o, 32'd0);
      end
      if (bus.rvm_res_rdy_o) begin lat = i; r = bus.res_o; break; end
      @(posedge clk); #1;
      // latched copies must be used, so scramble the live operands
      bus.op1_i = $urandom; bus.op2_i = $urandom;
    end
    chk({tag, "/lat"}, 32'(lat), 32'(lexp));
    chk({tag, "/res"}, r, e);
    @(posedge clk); #1;
    if (!keep) begin
      bus.rvm_cmd_vd_i = 1'b0;
      @(negedge clk);
      chk({tag, "/pulse_w"}, 32'(bus.rvm_res_rdy_o), 32'd0);
      chk({tag, "/busy_end"}, 32'(bus.busy_o), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rc;
    bit          seen;
    bus.rvm_cmd_vd_i = 1'b0; bus.cmd_i = '0; bus.op1_i = '0; bus.op2_i = '0;
    #12;
    chk("rst/rdy", 32'(bus.rvm_res_rdy_o), 32'd0);
    chk("rst/busy", 32'(bus.busy_o), 32'd0);
    chk("rst/res", bus.res_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run(3'd0, 32'h00000007, 32'hFFFFFFFD, 0, "mul");
    run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhu");
    run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulh");
    run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhsu");
    run(3'd4, 32'hFFFFFFF9, 32'd2, 0, "div");
    run(3'd6, 32'hFFFFFFF9, 32'd2, 0, "rem");
    run(3'd5, 32'd100, 32'd7, 0, "divu");
    run(3'd7, 32'd100, 32'd7, 0, "remu");
    run(3'd4, 32'h1234, 32'd0, 0, "div0");
    run(3'd5, 32'h1234, 32'd0, 0, "divu0");
    run(3'd6, 32'h1234, 32'd0, 0, "rem0");
    run(3'd7, 32'h1234, 32'd0, 0, "remu0");
    run(3'd6, 32'hFFFFFF00, 32'd0, 0, "rem0neg");
    run(3'd4, 32'h80000000, 32'hFFFFFFFF, 0, "divovf");
    run(3'd6, 32'h80000000, 32'hFFFFFFFF, 0, "removf");

    // Abort at ITER cycle 10, then a new command right away
    bus.cmd_i = 3'd5; bus.op1_i = 32'd1000; bus.op2_i = 32'd7; bus.rvm_cmd_vd_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.rvm_cmd_vd_i = 1'b0;
    @(negedge clk);
    chk("abort/rdy", 32'(bus.rvm_res_rdy_o), 32'd0);
    @(negedge clk);
    chk("abort/busy", 32'(bus.busy_o), 32'd0);
    chk("abort/rdy2", 32'(bus.rvm_res_rdy_o), 32'd0);
    @(posedge clk); #1;
    run(3'd5, 32'd9, 32'd3, 0, "after_abort");

    // Asynchronous reset mid-ITER
    bus.cmd_i = 3'd4; bus.op1_i = 32'd77; bus.op2_i = 32'd5; bus.rvm_cmd_vd_i = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_iter/busy", 32'(bus.busy_o), 32'd0);
    chk("arst_iter/rdy", 32'(bus.rvm_res_rdy_o), 32'd0);
    chk("arst_iter/res", bus.res_o, 32'd0);
    bus.rvm_cmd_vd_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset while the result is on the bus
    bus.cmd_i = 3'd5; bus.op1_i = 32'd100; bus.op2_i = 32'd7; bus.rvm_cmd_vd_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (bus.rvm_res_rdy_o) begin seen = 1'b1; break; end
    end
    chk("arst_corr/seen", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_corr/rdy", 32'(bus.rvm_res_rdy_o), 32'd0);
    chk("arst_corr/res", bus.res_o, 32'd0);
    chk("arst_corr/busy", 32'(bus.busy_o), 32'd0);
    bus.rvm_cmd_vd_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back with no idle gap
    run(3'd0, 32'h12345678, 32'h9ABCDEF0, 1, "b2b_mul");
    run(3'd7, 32'hDEADBEEF, 32'h00001234, 0, "b2b_remu");

    // Randomized commands, some with edge-case operands
    for (int k = 0; k < 60; k++) begin
      rc = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'hFFFFFFFF;
        default: ;
      endcase
      run(rc, ra, rb, bit'($urandom_range(0, 1)), $sformatf("rnd%0d_c%0d", k, rc));
    end
    bus.rvm_cmd_vd_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
